irq_ctl: RTL and testbench

- Sixteen-input interrupt controller directly downstream of the programmable timer and the other peripheral irq sources.
- Synchronises, latches, masks and prioritises the lines.
- Presents one registered interrupt request plus a 4-bit vector to the CPU.
- Register-mapped on the same stb/we/addr/ack bus slave protocol as the timer.

---
 rtl/irq_ctl.sv | 100 ++++++++++
 tb/tb_irq_ctl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctl.sv
// irq_ctl: sixteen-line interrupt controller on the stb/we/addr/ack slave bus.
// Synchronises, latches, masks and prioritises requests into one cpu irq + vector.
module irq_ctl #(
    parameter logic [15:0] EDGE_MASK = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stb,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        ack,
    input  logic [15:0] irq_in,
    output logic        cpu_irq,
    output logic [3:0]  cpu_vec
);

    localparam logic [1:0] A_PEND = 2'b00;
    localparam logic [1:0] A_EN   = 2'b01;
    localparam logic [1:0] A_STAT = 2'b10;
    localparam logic [1:0] A_CTRL = 2'b11;

    logic [15:0] r_sync1;
    logic [15:0] r_sync2;
    logic [15:0] r_sync3;
    logic [15:0] r_pending;
    logic [15:0] r_enable;
    logic        r_gen;
    logic        r_cpu_irq;
    logic [3:0]  r_cpu_vec;

    logic        w_wr;
    logic [15:0] w_w1c;
    logic [15:0] w_rise;
    logic [15:0] w_pend_nxt;
    logic [15:0] w_act;
    logic        w_active;
    logic [3:0]  w_vec;
    logic        w_unused;

    assign w_wr     = stb & we;
    assign w_unused = ^data_in[31:16];

    // W1C only reaches edge lines; level bits always follow sync2
    assign w_w1c  = (w_wr && addr == A_PEND) ? (data_in[15:0] & EDGE_MASK) : 16'h0;
    assign w_rise = r_sync2 & ~r_sync3 & EDGE_MASK;

    assign w_pend_nxt = (r_sync2 & ~EDGE_MASK)
                      | ((w_rise | (r_pending & ~w_w1c)) & EDGE_MASK);

    assign w_act    = r_pending & r_enable;
    assign w_active = |w_act;

    // descending scan so the lowest active index is the last one assigned
    always_comb begin
        w_vec = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (w_act[i]) w_vec = 4'(i);
        end
    end

    always_comb begin
        data_out = 32'h0;
        unique case (addr)
            A_PEND: data_out = {16'h0, r_pending};
            A_EN:   data_out = {16'h0, r_enable};
            A_STAT: data_out = {w_active, 27'h0, w_vec};
            A_CTRL: data_out = {31'h0, r_gen};
            default: data_out = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= 16'h0;
            r_sync2   <= 16'h0;
            r_sync3   <= 16'h0;
            r_pending <= 16'h0;
            r_enable  <= 16'h0;
            r_gen     <= 1'b0;
            r_cpu_irq <= 1'b0;
            r_cpu_vec <= 4'd0;
        end else begin
            r_sync1   <= irq_in;
            r_sync2   <= r_sync1;
            r_sync3   <= r_sync2;
            r_pending <= w_pend_nxt;
            if (w_wr && addr == A_EN)   r_enable <= data_in[15:0];
            if (w_wr && addr == A_CTRL) r_gen    <= data_in[0];
            r_cpu_irq <= r_gen & w_active;
            r_cpu_vec <= (r_gen & w_active) ? w_vec : 4'd0;
        end
    end

    assign ack     = stb;
    assign cpu_irq = r_cpu_irq;
    assign cpu_vec = r_cpu_vec;

endmodule

// File: tb/tb_irq_ctl.sv
// tb_irq_ctl: directed scenarios plus random traffic for irq_ctl,
// checked every cycle against a sample-history reference model.
module tb_irq_ctl;

    localparam logic [15:0] EM = 16'hF0E0;

    logic        clk = 1'b0;
    logic        rst;
    logic        stb;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        ack;
    logic [15:0] irq_in;
    logic        cpu_irq;
    logic [3:0]  cpu_vec;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    irq_ctl #(.EDGE_MASK(EM)) dut (
        .clk(clk), .rst(rst), .stb(stb), .we(we), .addr(addr),
        .data_in(data_in), .data_out(data_out), .ack(ack),
        .irq_in(irq_in), .cpu_irq(cpu_irq), .cpu_vec(cpu_vec)
    );

    // reference state; hist[n] = irq_in value sampled n+1 edges ago
    logic [15:0] m_pend, m_en;
    logic        m_gen, m_irq;
    logic [3:0]  m_vec;
    logic [15:0] hist [3];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [15:0] v);
        for (int i = 0; i < 16; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic logic [31:0] m_read(input logic [1:0] a);
        logic [15:0] act;
        act = m_pend & m_en;
        case (a)
            2'd0: return {16'h0, m_pend};
            2'd1: return {16'h0, m_en};
            2'd2: return {(act != 0), 27'h0, 4'(lowest(act))};
            default: return {31'h0, m_gen};
        endcase
    endfunction

    task automatic m_step(input logic s, input logic w, input logic [1:0] a,
                          input logic [31:0] d, input logic [15:0] irq,
                          input logic r);
        logic [15:0] act, np;
        if (r) begin
            m_pend = 0; m_en = 0; m_gen = 0; m_irq = 0; m_vec = 0;
            for (int i = 0; i < 3; i++) hist[i] = 0;
            return;
        end
        act   = m_pend & m_en;
        m_irq = m_gen && (act != 0);
        m_vec = m_irq ? 4'(lowest(act)) : 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (!EM[i])                          np[i] = hist[1][i];
            else if (hist[1][i] && !hist[2][i])  np[i] = 1'b1;
            else if (s && w && a == 0 && d[i])   np[i] = 1'b0;
            else                                 np[i] = m_pend[i];
        end
        m_pend = np;
        if (s && w && a == 1) m_en  = d[15:0];
        if (s && w && a == 3) m_gen = d[0];
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = irq;
    endtask

    task automatic cyc(input logic s, input logic w, input logic [1:0] a,
                       input logic [31:0] d, input logic [15:0] irq,
                       input logic r);
        @(negedge clk);
        stb = s; we = w; addr = a; data_in = d; irq_in = irq; rst = r;
        #1;
        check("ack", 32'(ack), 32'(s));
        check("rdata", data_out, m_read(a));
        @(posedge clk);
        m_step(s, w, a, d, irq, r);
        #1;
        check("cpu_irq", 32'(cpu_irq), 32'(m_irq));
        check("cpu_vec", 32'(cpu_vec), 32'(m_vec));
    endtask

    task automatic peek(input string tag, input logic [1:0] a,
                        input logic [31:0] exp);
        stb = 1'b1; we = 1'b0; addr = a;
        #1;
        check(tag, data_out, exp);
        check("peek_ack", 32'(ack), 32'd1);
        stb = 1'b0;
    endtask

    task automatic idle(input int n, input logic [15:0] irq);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, irq, 0);
    endtask

    initial begin
        logic [15:0] ri;
        rst = 1; stb = 0; we = 0; addr = 0; data_in = 0; irq_in = 0;
        repeat (2) @(posedge clk);
        m_step(0, 0, 0, 0, 0, 1);
        #1;
        check("rst_irq", 32'(cpu_irq), 32'd0);
        check("rst_vec", 32'(cpu_vec), 32'd0);
        for (int a = 0; a < 4; a++) peek("rst_read", 2'(a), 32'h0);

        // level line 3
        cyc(1, 1, 1, 32'h8, 0, 0);
        cyc(1, 1, 3, 32'h1, 0, 0);
        idle(3, 16'h8);
        check("lvl_lat", 32'(cpu_irq), 32'd0);
        idle(1, 16'h8);
        check("lvl_irq", 32'(cpu_irq), 32'd1);
        check("lvl_vec", 32'(cpu_vec), 32'd3);
        cyc(1, 1, 0, 32'h8, 16'h8, 0);
        peek("lvl_w1c", 0, 32'h8);
        idle(3, 16'h0);
        check("lvl_hold", 32'(cpu_irq), 32'd1);
        idle(1, 16'h0);
        check("lvl_drop", 32'(cpu_irq), 32'd0);

        // priority
        cyc(1, 1, 1, 32'hFFFF, 16'h0204, 0);
        idle(3, 16'h0204);
        check("pri_vec2", 32'(cpu_vec), 32'd2);
        cyc(1, 1, 1, 32'hFFFB, 16'h0204, 0);
        check("pri_old", 32'(cpu_vec), 32'd2);
        idle(1, 16'h0204);
        check("pri_vec9", 32'(cpu_vec), 32'd9);
        peek("pri_stat", 2, 32'h80000009);

        // edge capture on line 5
        idle(4, 16'h0);
        cyc(0, 0, 0, 0, 16'h0020, 0);
        idle(3, 16'h0);
        peek("edge_pend", 0, 32'h20);
        check("edge_vec", 32'(cpu_vec), 32'd5);
        idle(2, 16'h0);
        peek("edge_stick", 0, 32'h20);
        cyc(1, 1, 0, 32'h20, 0, 0);
        peek("edge_clr", 0, 32'h0);
        check("edge_irq_old", 32'(cpu_irq), 32'd1);
        idle(1, 16'h0);
        check("edge_irq_drop", 32'(cpu_irq), 32'd0);

        // set wins over simultaneous clear
        cyc(0, 0, 0, 0, 16'h0020, 0);
        idle(1, 16'h0);
        cyc(1, 1, 0, 32'h20, 0, 0);
        peek("setclr", 0, 32'h20);
        cyc(1, 1, 0, 32'h20, 0, 0);
        peek("setclr_done", 0, 32'h0);

        // global gate and mid-request reset
        cyc(1, 1, 3, 32'h0, 16'h8, 0);
        idle(4, 16'h8);
        peek("gate_pend", 0, 32'h8);
        peek("gate_stat", 2, 32'h80000003);
        check("gate_off", 32'(cpu_irq), 32'd0);
        cyc(1, 1, 3, 32'h1, 16'h8, 0);
        check("gate_lat", 32'(cpu_irq), 32'd0);
        idle(1, 16'h8);
        check("gate_on", 32'(cpu_irq), 32'd1);
        cyc(0, 0, 0, 0, 16'h8, 1);
        check("mid_rst_irq", 32'(cpu_irq), 32'd0);
        check("mid_rst_vec", 32'(cpu_vec), 32'd0);
        peek("mid_rst_pend", 0, 32'h0);
        idle(2, 16'h0);

        // random traffic against the model
        ri = 16'h0;
        for (int n = 0; n < 400; n++) begin
            logic [1:0] a;
            logic [31:0] d;
            ri = ri ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
            a = 2'($urandom_range(0, 3));
            d = $urandom;
            if (a == 3) d = 32'($urandom_range(0, 7) != 0);
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                a, d, ri, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
